// File: rtl/path_request_arbiter_pkg.sv
// path_arb_pkg
// Shared types and default sizes for the path request arbiter slice.
//   arb_state_t : controller states. DRAIN only exists when PATH_ARB_TIMEOUT_EN
//                 is defined, because only a timed-out run can leave the planner busy.
//   NODE_W, PATH_LEN, PATH_W : default node width, path length and packed path width.
package path_arb_pkg;

   localparam int NODE_W   = 5;
   localparam int PATH_LEN = 10;
   localparam int PATH_W   = PATH_LEN * NODE_W;

   typedef enum logic [2:0] {
      IDLE,
      START,
      RUN,
`ifdef PATH_ARB_TIMEOUT_EN
      RESP,
      DRAIN
`else
      RESP
`endif
   } arb_state_t;

endpackage

// File: rtl/path_request_arbiter_if.sv
// path_request_arbiter_if
// Requester-side bus of the path request arbiter.
//   req_valid  : per-requester request, held until req_ready pulses
//   req_ready  : one-hot accept pulse
//   req_s_node : packed start nodes, slice i = [i*NODE_W +: NODE_W]
//   req_e_node : packed end nodes, same packing
//   rsp_valid  : one-hot one-cycle response pulse to the owner
//   rsp_path   : returned path, meaningful while rsp_valid is non-zero
//   rsp_err    : error flag, meaningful with rsp_valid
// Modports: master = requester side, slave = arbiter side.
interface path_request_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int NODE_W = path_arb_pkg::NODE_W,
   parameter int PATH_W = path_arb_pkg::PATH_W
);

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*NODE_W-1:0] req_s_node;
   logic [NREQ*NODE_W-1:0] req_e_node;
   logic [NREQ-1:0]        rsp_valid;
   logic [PATH_W-1:0]      rsp_path;
   logic                   rsp_err;

   modport master (
      output req_valid, req_s_node, req_e_node,
      input  req_ready, rsp_valid, rsp_path, rsp_err
   );

   modport slave (
      input  req_valid, req_s_node, req_e_node,
      output req_ready, rsp_valid, rsp_path, rsp_err
   );

endinterface

// File: rtl/path_request_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin priority encoder. The search starts at ptr and
// wraps, so the first set request bit at or after ptr wins.
//   req   in  NREQ   request vector
//   ptr   in  IDX_W  highest-priority position
//   grant out NREQ   one-hot winner (zero when no request)
//   idx   out IDX_W  winner index
//   any   out 1      at least one request present
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W:0]   pos;
   logic [IDX_W-1:0] cand;

   // Walk the NREQ positions starting at ptr; pos carries one extra bit so the
   // wrap back to zero is a single subtraction even when NREQ is not a power of two.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(i);
         if (pos >= (IDX_W+1)'(NREQ)) begin
            pos = pos - (IDX_W+1)'(NREQ);
         end
         cand = pos[IDX_W-1:0];
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/path_request_arbiter.sv
// path_request_arbiter
// Shares one path_planner between NREQ requesters. Requests are granted
// round-robin, the winner's nodes drive the planner through its level-style
// start/done handshake, and the finished path goes back to the winner with a
// one-cycle rsp_valid pulse. Out-of-range nodes are answered with rsp_err
// without starting the planner.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_bus        requester bus (slave modport of path_request_arbiter_if)
//   pp_start       planner start, held until the planner reports busy
//   pp_s_node/e    planner start/end node
//   pp_done        planner status: 1 = idle/finished, 0 = busy
//   pp_final_path  planner result
// Optional feature: define PATH_ARB_TIMEOUT_EN to bound each planner run to
// TIMEOUT cycles; a timed-out run answers with rsp_err and then waits in
// DRAIN until the planner goes idle.
module path_request_arbiter #(
   parameter int NREQ      = 4,
   parameter int NODE_W    = path_arb_pkg::NODE_W,
   parameter int PATH_LEN  = path_arb_pkg::PATH_LEN,
   parameter int NUM_NODES = 32
`ifdef PATH_ARB_TIMEOUT_EN
   , parameter int TIMEOUT = 4095
`endif
   , localparam int PATH_W = PATH_LEN * NODE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   path_request_arbiter_if.slave req_bus,
   output logic                  pp_start,
   output logic [NODE_W-1:0]     pp_s_node,
   output logic [NODE_W-1:0]     pp_e_node,
   input  logic                  pp_done,
   input  logic [PATH_W-1:0]     pp_final_path
);

   import path_arb_pkg::*;

   localparam int IDX_W = $clog2(NREQ);

   arb_state_t        state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  owner;
   logic [NREQ-1:0]   owner_oh;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [PATH_W-1:0] rsp_path;
   logic              rsp_err;

   logic [NREQ-1:0]   win_grant;
   logic [IDX_W-1:0]  win_idx;
   logic              win_any;
   logic [NODE_W-1:0] win_s;
   logic [NODE_W-1:0] win_e;
   logic              win_bad;
   logic              timeout_hit;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (req_bus.req_valid),
      .ptr   (rr_ptr),
      .grant (win_grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   assign win_s    = req_bus.req_s_node[win_idx*NODE_W +: NODE_W];
   assign win_e    = req_bus.req_e_node[win_idx*NODE_W +: NODE_W];
   assign win_bad  = (int'(win_s) >= NUM_NODES) || (int'(win_e) >= NUM_NODES);
   assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner;

`ifdef PATH_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] run_cnt;
   logic             timed_out;

   assign timeout_hit = ((state == START) || (state == RUN)) &&
                        (run_cnt == CNT_W'(TIMEOUT - 1));

   // Run-length counter: cleared on the grant that enters START, then counts
   // every START/RUN cycle. timed_out remembers that RESP must hand over to DRAIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt   <= '0;
         timed_out <= 1'b0;
      end else if (state == IDLE) begin
         run_cnt   <= '0;
         timed_out <= 1'b0;
      end else if (timeout_hit) begin
         timed_out <= 1'b1;
      end else if ((state == START) || (state == RUN)) begin
         run_cnt <= run_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Main controller. All outputs are registered; req_ready and rsp_valid are
   // single-cycle pulses so they default to zero every cycle. A grant only
   // happens while the planner reports idle, which also covers a planner that
   // is still finishing a run abandoned by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_path  <= '0;
         rsp_err   <= 1'b0;
         pp_start  <= 1'b0;
         pp_s_node <= '0;
         pp_e_node <= '0;
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
         if (timeout_hit) begin
            pp_start  <= 1'b0;
            rsp_valid <= owner_oh;
            rsp_err   <= 1'b1;
            rsp_path  <= '0;
            state     <= RESP;
         end else begin
            case (state)
               IDLE: begin
                  if (win_any && pp_done) begin
                     req_ready <= win_grant;
                     owner     <= win_idx;
                     pp_s_node <= win_s;
                     pp_e_node <= win_e;
                     rr_ptr    <= (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                     if (win_bad) begin
                        rsp_valid <= win_grant;
                        rsp_err   <= 1'b1;
                        rsp_path  <= '0;
                        state     <= RESP;
                     end else begin
                        state <= START;
                     end
                  end
               end
               // pp_start rises one edge after the grant and drops on the edge
               // that first samples the planner busy.
               START: begin
                  if (pp_start && !pp_done) begin
                     pp_start <= 1'b0;
                     state    <= RUN;
                  end else begin
                     pp_start <= 1'b1;
                  end
               end
               RUN: begin
                  if (pp_done) begin
                     rsp_path  <= pp_final_path;
                     rsp_err   <= 1'b0;
                     rsp_valid <= owner_oh;
                     state     <= RESP;
                  end
               end
               RESP: begin
`ifdef PATH_ARB_TIMEOUT_EN
                  state <= timed_out ? DRAIN : IDLE;
`else
                  state <= IDLE;
`endif
               end
`ifdef PATH_ARB_TIMEOUT_EN
               DRAIN: begin
                  pp_start <= 1'b0;
                  if (pp_done) begin
                     state <= IDLE;
                  end
               end
`endif
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign req_bus.req_ready = req_ready;
   assign req_bus.rsp_valid = rsp_valid;
   assign req_bus.rsp_path  = rsp_path;
   assign req_bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_path_request_arbiter.sv
// tb_path_request_arbiter
// Scoreboard bench for path_request_arbiter. Stimulus pushes the expected
// grant order and responses into queues; a monitor pops and compares them
// whenever the DUT pulses req_ready or rsp_valid. A behavioural planner
// model answers pp_start with a configurable busy time. The timeout case is
// built only when PATH_ARB_TIMEOUT_EN is defined.
module tb_path_request_arbiter;

   localparam int NREQ      = 4;
   localparam int NODE_W    = 5;
   localparam int PATH_LEN  = 10;
   localparam int PATH_W    = PATH_LEN * NODE_W;
   localparam int NUM_NODES = 20;
`ifdef PATH_ARB_TIMEOUT_EN
   localparam int TIMEOUT   = 100;
`endif

   typedef struct {
      int                owner;
      logic [PATH_W-1:0] path;
      logic              err;
   } rsp_t;

   logic              clk;
   logic              rst_n;
   logic              pp_start;
   logic [NODE_W-1:0] pp_s_node;
   logic [NODE_W-1:0] pp_e_node;
   logic              pp_done;
   logic [PATH_W-1:0] pp_final_path;

   path_request_arbiter_if #(.NREQ(NREQ), .NODE_W(NODE_W), .PATH_W(PATH_W)) bus ();

   path_request_arbiter #(
      .NREQ      (NREQ),
      .NODE_W    (NODE_W),
      .PATH_LEN  (PATH_LEN),
      .NUM_NODES (NUM_NODES)
`ifdef PATH_ARB_TIMEOUT_EN
      , .TIMEOUT (TIMEOUT)
`endif
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_bus       (bus),
      .pp_start      (pp_start),
      .pp_s_node     (pp_s_node),
      .pp_e_node     (pp_e_node),
      .pp_done       (pp_done),
      .pp_final_path (pp_final_path)
   );

   int   compared;
   int   mismatched;
   int   grants;
   int   resps;
   int   start_in_run;
   int   early_drop;
   int   start_rises;
   int   cyc;
   int   start_rise_cyc;
   int   rsp_cyc;
   logic rsp_pp_start;
   logic prev_start;
   bit   hang;
   bit   check_early;
   int   model_lat;
   rsp_t rq[$];
   int   gq[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference path for a request: s, s+3, s+6 ... (mod 32) and then e.
   function automatic logic [PATH_W-1:0] model_path(input logic [NODE_W-1:0] s,
                                                    input logic [NODE_W-1:0] e);
      logic [PATH_W-1:0] p;
      p = '0;
      for (int k = 0; k < PATH_LEN - 1; k++) begin
         p[k*NODE_W +: NODE_W] = s + NODE_W'(3 * k);
      end
      p[(PATH_LEN-1)*NODE_W +: NODE_W] = e;
      return p;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Planner model: accepts a start at the falling edge, goes busy for
   // model_lat cycles, then presents the path built from the nodes it saw.
   initial begin
      logic [NODE_W-1:0] ms;
      logic [NODE_W-1:0] me;
      pp_done       = 1'b1;
      pp_final_path = '0;
      forever begin
         @(negedge clk);
         if (pp_start && pp_done && !hang) begin
            ms      = pp_s_node;
            me      = pp_e_node;
            pp_done = 1'b0;
            repeat (model_lat) @(negedge clk);
            pp_final_path = model_path(ms, me);
            pp_done       = 1'b1;
         end
      end
   end

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      rsp_t r;
      int   g;
      prev_start = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst_n) begin
            if (bus.req_ready != '0) begin
               grants++;
               if (gq.size() == 0) begin
                  check_output("grant_unexpected", 64'(bus.req_ready), 64'd0);
               end else begin
                  g = gq.pop_front();
                  check_output("grant_onehot", 64'(bus.req_ready), 64'(1) << g);
               end
            end
            if (bus.rsp_valid != '0) begin
               resps++;
               rsp_cyc      = cyc;
               rsp_pp_start = pp_start;
               if (rq.size() == 0) begin
                  check_output("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
               end else begin
                  r = rq.pop_front();
                  check_output("rsp_valid", 64'(bus.rsp_valid), 64'(1) << r.owner);
                  check_output("rsp_path", 64'(bus.rsp_path), 64'(r.path));
                  check_output("rsp_err", 64'(bus.rsp_err), 64'(r.err));
               end
            end
            if (pp_start && !pp_done) start_in_run++;
            if (check_early && prev_start && !pp_start && pp_done) early_drop++;
            if (pp_start && !prev_start) begin
               start_rises++;
               start_rise_cyc = cyc;
            end
            prev_start = pp_start;
         end
      end
   end

   task automatic set_nodes(input int idx, input logic [NODE_W-1:0] s, input logic [NODE_W-1:0] e);
      bus.req_s_node[idx*NODE_W +: NODE_W] = s;
      bus.req_e_node[idx*NODE_W +: NODE_W] = e;
   endtask

   task automatic expect_rsp(input int owner, input logic [PATH_W-1:0] path, input logic err);
      rsp_t r;
      r.owner = owner;
      r.path  = path;
      r.err   = err;
      rq.push_back(r);
   endtask

   // Raise the masked requests and wait for n grants among them; with drop
   // set, each requester lowers req_valid once it has been accepted.
   task automatic apply_stimulus(input logic [NREQ-1:0] mask, input int n, input bit drop);
      int seen;
      seen = 0;
      bus.req_valid = bus.req_valid | mask;
      for (int c = 0; c < 400 && seen < n; c++) begin
         @(posedge clk);
         #1;
         if ((bus.req_ready & mask) != '0) begin
            seen++;
            if (drop) bus.req_valid = bus.req_valid & ~bus.req_ready;
         end
      end
      bus.req_valid = bus.req_valid & ~mask;
      check_output("grant_count", 64'(seen), 64'(n));
   endtask

   task automatic wait_resps(input int target, input int budget);
      for (int c = 0; c < budget && resps < target; c++) begin
         @(posedge clk);
         #1;
      end
      check_output("rsp_count", 64'(resps), 64'(target));
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
      check_output({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
      check_output({tag, "_rsp_path"}, 64'(bus.rsp_path), 64'd0);
      check_output({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
      check_output({tag, "_pp_start"}, 64'(pp_start), 64'd0);
      check_output({tag, "_pp_s_node"}, 64'(pp_s_node), 64'd0);
      check_output({tag, "_pp_e_node"}, 64'(pp_e_node), 64'd0);
   endtask

   initial begin
      int rises_before;
      compared       = 0;
      mismatched     = 0;
      grants         = 0;
      resps          = 0;
      start_in_run   = 0;
      early_drop     = 0;
      start_rises    = 0;
      cyc            = 0;
      start_rise_cyc = 0;
      rsp_cyc        = 0;
      rsp_pp_start   = 1'b0;
      hang           = 1'b0;
      check_early    = 1'b1;
      model_lat      = 1000;
      rst_n          = 1'b0;
      bus.req_valid  = '0;
      bus.req_s_node = '0;
      bus.req_e_node = '0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] single request, planner busy 1000 cycles");
      set_nodes(0, 5'd0, 5'd8);
      gq.push_back(0);
      expect_rsp(0, model_path(5'd0, 5'd8), 1'b0);
      apply_stimulus(4'b0001, 1, 1'b1);
      wait_resps(1, 1300);

      $display("[TB] contention between requesters 1 and 3");
      model_lat = 12;
      set_nodes(1, 5'd1, 5'd16);
      set_nodes(3, 5'd11, 5'd10);
      gq.push_back(1);
      gq.push_back(3);
      expect_rsp(1, model_path(5'd1, 5'd16), 1'b0);
      expect_rsp(3, model_path(5'd11, 5'd10), 1'b0);
      apply_stimulus(4'b1010, 2, 1'b1);
      wait_resps(3, 200);

      $display("[TB] wrap fairness over 8 runs");
      model_lat = 8;
      for (int i = 0; i < NREQ; i++) set_nodes(i, NODE_W'(i + 2), NODE_W'(i + 12));
      for (int k = 0; k < 8; k++) begin
         gq.push_back(k % NREQ);
         expect_rsp(k % NREQ, model_path(NODE_W'((k % NREQ) + 2), NODE_W'((k % NREQ) + 12)), 1'b0);
      end
      apply_stimulus(4'b1111, 8, 1'b0);
      wait_resps(11, 400);
      check_output("pp_start_in_run", 64'(start_in_run), 64'd0);
      check_output("pp_start_early_drop", 64'(early_drop), 64'd0);

      $display("[TB] out-of-range end node");
      rises_before = start_rises;
      set_nodes(2, 5'd3, 5'd25);
      gq.push_back(2);
      expect_rsp(2, '0, 1'b1);
      apply_stimulus(4'b0100, 1, 1'b1);
      wait_resps(12, 50);
      repeat (5) @(posedge clk);
      #1;
      check_output("invalid_no_pp_start", 64'(start_rises - rises_before), 64'd0);

      $display("[TB] reset during a planner run");
      model_lat = 40;
      set_nodes(0, 5'd4, 5'd6);
      gq.push_back(0);
      apply_stimulus(4'b0001, 1, 1'b1);
      for (int c = 0; c < 20 && pp_done; c++) begin
         @(posedge clk);
         #1;
      end
      check_output("run_entered", 64'(pp_done), 64'd0);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_values("midrun");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      set_nodes(0, 5'd9, 5'd9);
      set_nodes(1, 5'd5, 5'd7);
      gq.push_back(0);
      gq.push_back(1);
      expect_rsp(0, model_path(5'd9, 5'd9), 1'b0);
      expect_rsp(1, model_path(5'd5, 5'd7), 1'b0);
      apply_stimulus(4'b0011, 2, 1'b1);
      wait_resps(14, 300);

`ifdef PATH_ARB_TIMEOUT_EN
      $display("[TB] planner never responds, timeout path");
      hang        = 1'b1;
      check_early = 1'b0;
      set_nodes(1, 5'd2, 5'd3);
      gq.push_back(1);
      expect_rsp(1, '0, 1'b1);
      apply_stimulus(4'b0010, 1, 1'b1);
      wait_resps(15, 300);
      check_output("timeout_window", 64'((rsp_cyc - start_rise_cyc >= 95) &&
                                         (rsp_cyc - start_rise_cyc <= 105)), 64'd1);
      check_output("timeout_pp_start", 64'(rsp_pp_start), 64'd0);
      hang      = 1'b0;
      model_lat = 6;
      set_nodes(2, 5'd4, 5'd5);
      gq.push_back(2);
      expect_rsp(2, model_path(5'd4, 5'd5), 1'b0);
      apply_stimulus(4'b0100, 1, 1'b1);
      wait_resps(16, 200);
`endif

      repeat (5) @(posedge clk);
      #1;
      check_output("pp_start_in_run_final", 64'(start_in_run), 64'd0);
      check_output("pp_start_early_drop_final", 64'(early_drop), 64'd0);
      check_output("rsp_queue_left", 64'(rq.size()), 64'd0);
      check_output("grant_queue_left", 64'(gq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
